qam_frame_sync: RTL

- Sits directly downstream of the QAM demodulator top and consumes its dout_valid/dout[3:0] symbol stream.
- Hunts for a 32-bit sync word in the nibble stream.
- Once locked, packs the following FRAME_BYTES*2 nibbles into bytes and emits them on an AXI4-Stream master through a small internal FIFO, with tlast on the final byte of each frame.

---
 rtl/qam_frame_sync.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/qam_frame_sync.sv
// qam_frame_sync: hunts for a 32-bit sync word in the demodulated nibble stream.
// After lock it packs the next FRAME_BYTES*2 nibbles into bytes and emits them on
// an AXI4-Stream master through a small FIFO, with tlast on the last byte of the frame.
// Build option: define QAM_SYNC_ERR_TOL_EN to accept a sync word with up to 2 bit errors.
module qam_frame_sync #(
  parameter logic [31:0] SYNC_WORD   = 32'h1ACF_FC1D,
  parameter int unsigned FRAME_BYTES = 64,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        axi_clk,
  input  logic        axi_rst,
  input  logic        dout_valid,
  input  logic [3:0]  dout,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        sync_lock,
  output logic [15:0] frame_cnt,
  output logic        overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0]   LAST_IDX = 16'(FRAME_BYTES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] sr_q;
  logic [3:0]  fill_q;
  logic [15:0] byte_cnt_q;
  logic        phase_q;
  logic [3:0]  hi_q;
  logic        push_q;
  logic [7:0]  push_data_q;
  logic        push_last_q;
  logic [15:0] frame_cnt_q;
  logic        sync_lock_q;
  logic        overflow_q;

  logic [31:0] sr_d;
  logic [3:0]  fill_d;
  logic        sync_hit;

  // Post-shift view of the sync shift register and saturating fill counter
  always_comb begin
    sr_d   = {sr_q[27:0], dout};
    fill_d = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
  end

`ifdef QAM_SYNC_ERR_TOL_EN
  logic [5:0] err_bits;

  // Hamming distance between the post-shift window and the sync word
  always_comb begin
    err_bits = '0;
    for (int i = 0; i < 32; i++) begin
      err_bits = err_bits + 6'(sr_d[i] ^ SYNC_WORD[i]);
    end
  end

  assign sync_hit = (fill_d == 4'd8) && (err_bits <= 6'd2);
`else
  assign sync_hit = (fill_d == 4'd8) && (sr_d == SYNC_WORD);
`endif

  // Frame FSM: sync hunt, nibble pairing and push strobe generation
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      fill_q      <= '0;
      byte_cnt_q  <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      push_last_q <= 1'b0;
      frame_cnt_q <= '0;
      sync_lock_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (dout_valid) begin
        case (state_q)
          HUNT: begin
            sr_q   <= sr_d;
            fill_q <= fill_d;
            if (sync_hit) begin
              state_q     <= PAYLOAD;
              byte_cnt_q  <= '0;
              phase_q     <= 1'b0;
              sync_lock_q <= 1'b1;
            end
          end
          PAYLOAD: begin
            if (!phase_q) begin
              hi_q    <= dout;
              phase_q <= 1'b1;
            end else begin
              push_q      <= 1'b1;
              push_data_q <= {hi_q, dout};
              push_last_q <= (byte_cnt_q == LAST_IDX);
              byte_cnt_q  <= byte_cnt_q + 16'd1;
              phase_q     <= 1'b0;
              // Frame complete: a fresh sync word is needed for the next frame
              if (byte_cnt_q == LAST_IDX) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                state_q     <= HUNT;
                sync_lock_q <= 1'b0;
                sr_q        <= '0;
                fill_q      <= '0;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  logic [7:0]    mem_data_q [FIFO_DEPTH];
  logic          mem_last_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          m_axis_tvalid_q;
  logic [7:0]    m_axis_tdata_q;
  logic          m_axis_tlast_q;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic [7:0]    head_data;
  logic          head_last;

  // FIFO control; the next head comes from the push itself when it lands at the read slot
  always_comb begin
    pop      = m_axis_tvalid_q && m_axis_tready;
    wr_en    = push_q && ((count_q != DEPTH_C) || pop);
    drop     = push_q && (count_q == DEPTH_C) && !pop;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(pop);
    if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      head_data = push_data_q;
      head_last = push_last_q;
    end else begin
      head_data = mem_data_q[rd_ptr_d];
      head_last = mem_last_q[rd_ptr_d];
    end
  end

  // FIFO storage
  always_ff @(posedge axi_clk) begin
    if (!axi_rst && wr_en) begin
      mem_data_q[wr_ptr_q] <= push_data_q;
      mem_last_q[wr_ptr_q] <= push_last_q;
    end
  end

  // FIFO pointers, registered stream outputs and sticky overflow
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      m_axis_tvalid_q <= 1'b0;
      m_axis_tdata_q  <= '0;
      m_axis_tlast_q  <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      m_axis_tvalid_q <= (count_d != '0);
      m_axis_tdata_q  <= head_data;
      m_axis_tlast_q  <= head_last;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign m_axis_tdata  = m_axis_tdata_q;
  assign m_axis_tvalid = m_axis_tvalid_q;
  assign m_axis_tlast  = m_axis_tlast_q;
  assign sync_lock     = sync_lock_q;
  assign frame_cnt     = frame_cnt_q;
  assign overflow      = overflow_q;

endmodule
